// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg: shared types and constants for the rx_credit_buf receive buffer.
`default_nettype none

package rx_buf_pkg;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } rd_state_e;

    localparam int DROP_CNT_W        = 16;
    localparam int STATUS_PERIOD_DEF = 2500;

endpackage

`default_nettype wire

// File: rtl/rx_buf_ram.sv
// rx_buf_ram: simple dual-port RAM (one write port, one read port, 1-cycle read latency).
`default_nettype none

module rx_buf_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/rx_credit_buf.sv
// rx_credit_buf: FWFT ring buffer with credit tracking, periodic status and overflow flagging.
// Optional macro RX_BUF_DROP_CNT_EN enables the saturating dropped-write counter.
`default_nettype none

module rx_credit_buf
    import rx_buf_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int DEPTH         = 1024,
    parameter int STATUS_PERIOD = STATUS_PERIOD_DEF,
    parameter int CNT_W         = $clog2(DEPTH) + 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      free_credits,
    output logic                  status_valid,
    output logic [CNT_W-1:0]      status_free,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (STATUS_PERIOD > 2) ? $clog2(STATUS_PERIOD) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [SW-1:0]    STAT_LAST = SW'(STATUS_PERIOD - 1);

    rd_state_e         state_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              full_q, empty_q;
    logic [CNT_W-1:0]  free_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] ram_rdata;
    logic [SW-1:0]     stat_cnt_q;
    logic              status_valid_q;
    logic [CNT_W-1:0]  status_free_q;
    logic              overflow_q;

    logic accept, drop, pop, issue, ram_has_word;

    assign accept       = wr_en && !full_q;
    assign drop         = wr_en && full_q;
    assign pop          = rd_valid_q && rd_ready;
    assign ram_has_word = (ram_cnt_q != '0);
    // A pop that frees the output register immediately refills it when the RAM has data.
    assign issue        = ram_has_word && ((state_q == RD_EMPTY) || (state_q == RD_VALID && pop));

    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        ram_cnt_d = ram_cnt_q;
        case ({accept, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    rx_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (ap_clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ram_cnt_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            free_q    <= DEPTH_C;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q     <= occ_d;
            ram_cnt_q <= ram_cnt_d;
            full_q    <= (occ_d == DEPTH_C);
            empty_q   <= (occ_d == '0);
            free_q    <= DEPTH_C - occ_d;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= RD_EMPTY;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (state_q)
                RD_EMPTY: begin
                    if (ram_has_word) state_q <= RD_FETCH;
                end
                RD_FETCH: begin
                    state_q    <= RD_VALID;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= ram_rdata;
                end
                RD_VALID: begin
                    if (pop) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= ram_has_word ? RD_FETCH : RD_EMPTY;
                    end
                end
                default: begin
                    state_q    <= RD_EMPTY;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stat_cnt_q     <= '0;
            status_valid_q <= 1'b0;
            status_free_q  <= DEPTH_C;
        end else begin
            status_valid_q <= (stat_cnt_q == STAT_LAST);
            if (stat_cnt_q == STAT_LAST) begin
                stat_cnt_q    <= '0;
                status_free_q <= free_q;
            end else begin
                stat_cnt_q <= stat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)       overflow_q <= 1'b0;
        else if (ovf_clr) overflow_q <= 1'b0;
        else if (drop)    overflow_q <= 1'b1;
    end

`ifdef RX_BUF_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)       drop_cnt_q <= '0;
        else if (ovf_clr) drop_cnt_q <= '0;
        else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
            drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign free_credits = free_q;
    assign status_valid = status_valid_q;
    assign status_free  = status_free_q;
    assign overflow     = overflow_q;

endmodule

`default_nettype wire
